mem_bus_ctrl: RTL and testbench
===============================

// Module: mem_bus_ctrl
// PURPOSE
//  Downstream of the TLB: consumes the translated physical address and the TLB exception flags.
//  Runs one multi-cycle SRAM access per request on a shared base/ext SRAM bus (bank picked by paddr_i[22]).
//  Returns read data, ack/err and a stall to the MEM stage.
//  Requests carrying a TLB exception are refused without touching SRAM.
// PARAMETERS
//  WAIT_CYCLES  2   SRAM access cycles per transfer (>=1); strobes held this many cycles
//  SRAM_AW      20  SRAM word-address width (word addr = paddr_i[SRAM_AW+1:2])
// PORTS
//  clk           in   1   system clock, all logic on rising edge
//  rst           in   1   synchronous active-high reset
//  req_i         in   1   access request, held until ack_o
//  we_i          in   1   1=write, 0=read; sampled with req_i in IDLE
//  sel_i         in   4   byte enables, bit i = byte lane i
//  paddr_i       in   32  physical address from TLB (tlb_addr)
//  wdata_i       in   32  write data
//  tlbm_i        in   1   TLB modify exception for this request
//  tlbl_i        in   1   TLB load-miss exception for this request
//  tlbs_i        in   1   TLB store-miss exception for this request
//  rdata_o       out  32  read data, valid while ack_o=1 and we=0
//  ack_o         out  1   one-cycle completion pulse
//  err_o         out  1   with ack_o: request refused due to TLB exception
//  stall_o       out  1   req_i & ~ack_o (combinational)
//  sram_addr_o   out  SRAM_AW  SRAM word address
//  sram_dout_o   out  32  SRAM write data
//  sram_din_i    in   32  SRAM read data
//  sram_doe_o    out  1   1=drive sram_dout_o onto bus (tristate enable)
//  sram_be_n_o   out  4   byte enables, active low (= ~sel)
//  sram_ce_n_o   out  2   chip enables, active low; [0]=base, [1]=ext
//  sram_oe_n_o   out  1   output enable, active low
//  sram_we_n_o   out  1   write enable, active low
// BEHAVIOUR
//  - Reset (sync, rst=1 at edge): state=IDLE, cnt=0, rdata_o=0, ack_o=0, err_o=0, sram_addr_o=0,
//    sram_dout_o=0, sram_doe_o=0, sram_be_n_o=4'hF, sram_ce_n_o=2'b11, oe_n=we_n=1.
//    Reset mid-access aborts immediately; no ack is issued.
//  - States: IDLE, ACCESS, DONE, FAULT.
//  - IDLE, req_i=1, any of tlbm_i/tlbl_i/tlbs_i=1 -> FAULT.
//    FAULT: ack_o=1, err_o=1 for one cycle; no SRAM strobe -> IDLE.
//  - IDLE, req_i=1, no exception: latch we/sel/paddr/wdata, cnt=0 -> ACCESS.
//    Drive addr = paddr[SRAM_AW+1:2]; ce_n[paddr[22]]=0, other ce_n=1; be_n = ~sel.
//    Read: oe_n=0, doe=0. Write: we_n=0, doe=1, dout=wdata.
//  - ACCESS: strobes held; cnt++. At cnt==WAIT_CYCLES-1:
//    read samples sram_din_i into rdata_o; all strobes deassert (ce_n=11, oe_n=we_n=1, doe=0); -> DONE.
//  - DONE: ack_o=1, err_o=0 for one cycle -> IDLE. Next request is accepted no earlier than the following cycle.
//  - Latency: request at cycle T (IDLE) -> ack at T+WAIT_CYCLES+1. Fault ack at T+1.
//  - Inputs change or req_i drops during ACCESS: ignored, access completes on latched values.
//  - rdata_o holds its value until the next read completes. Writes leave rdata_o unchanged.
//  - sel_i=0 still runs a full access, with be_n=F.
//  - Never assert oe_n=0 and we_n=0 together. doe=1 only while we_n=0.
// TESTING
//  1 rst for 2 cycles mid-write -> next cycle: all strobes inactive, ack_o=0, state IDLE.
//  2 Write paddr=0x0000_1004, sel=F, wdata=0xDEADBEEF -> addr=0x00401, ce_n=10, we_n=0 for 2 cycles, ack at T+3, err=0.
//  3 Read back paddr=0x0000_1004 (SRAM model returns 0xDEADBEEF) -> rdata_o=0xDEADBEEF with ack at T+3, oe_n=0 for 2 cycles.
//  4 Read paddr=0x0040_0008 -> ce_n=01 (ext bank), addr=0x00002; sel=4'b0011 -> be_n=4'b1100.
//  5 req with tlbs_i=1 -> ack_o=err_o=1 at T+1, ce_n stays 11 throughout, rdata_o unchanged.
//  6 Back-to-back requests held on req_i -> stall_o=1 except ack cycles; no overlapping strobes; WAIT_CYCLES=1 variant ack at T+2.

Source files
------------

// File: rtl/mem_bus_ctrl_if.sv
// rtl/mem_bus_ctrl_if.sv - MEM-stage request/response bundle for mem_bus_ctrl
//
// Purpose: carries one translated memory request from the MEM stage (with the
// TLB exception flags) to the SRAM bus controller, and carries completion back.
//
// Signals:
//   req_i                   request, held by the master until ack_o
//   we_i, sel_i             write/read select and byte enables
//   paddr_i, wdata_i        physical address and write data
//   tlbm_i, tlbl_i, tlbs_i  TLB modify / load-miss / store-miss exceptions
//   rdata_o                 read data, valid with ack_o on a read
//   ack_o, err_o            completion pulse, refusal flag
//   stall_o                 pipeline stall (req_i & ~ack_o)
// Modports: master = MEM stage, slave = controller.
interface mem_bus_ctrl_if;
  logic        req_i;
  logic        we_i;
  logic [3:0]  sel_i;
  logic [31:0] paddr_i;
  logic [31:0] wdata_i;
  logic        tlbm_i;
  logic        tlbl_i;
  logic        tlbs_i;
  logic [31:0] rdata_o;
  logic        ack_o;
  logic        err_o;
  logic        stall_o;

  modport master (
    output req_i, we_i, sel_i, paddr_i, wdata_i, tlbm_i, tlbl_i, tlbs_i,
    input  rdata_o, ack_o, err_o, stall_o
  );

  modport slave (
    input  req_i, we_i, sel_i, paddr_i, wdata_i, tlbm_i, tlbl_i, tlbs_i,
    output rdata_o, ack_o, err_o, stall_o
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - multi-cycle SRAM access controller behind the TLB
//
// Purpose: runs one SRAM access per request on a shared base/ext SRAM bus,
// bank chosen by paddr_i[22]. Requests flagged with a TLB exception are
// refused (ack+err) without touching SRAM.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   bus             mem_bus_ctrl_if.slave request/response bundle
//   sram_addr_o     SRAM word address (paddr_i[SRAM_AW+1:2])
//   sram_dout_o     SRAM write data, sram_doe_o = drive enable
//   sram_din_i      SRAM read data
//   sram_be_n_o     byte enables, active low
//   sram_ce_n_o     chip enables, active low, [0]=base [1]=ext
//   sram_oe_n_o     output enable, active low
//   sram_we_n_o     write enable, active low
module mem_bus_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_AW     = 20
) (
  input  logic               clk,
  input  logic               rst,
  mem_bus_ctrl_if.slave      bus,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [31:0]        sram_dout_o,
  input  logic [31:0]        sram_din_i,
  output logic               sram_doe_o,
  output logic [3:0]         sram_be_n_o,
  output logic [1:0]         sram_ce_n_o,
  output logic               sram_oe_n_o,
  output logic               sram_we_n_o
);

  // A counter of at least one bit keeps WAIT_CYCLES=1 legal.
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, FAULT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          we_q;
  logic          tlb_exc;
  logic          unused_paddr;

  assign tlb_exc      = bus.tlbm_i | bus.tlbl_i | bus.tlbs_i;
  assign bus.stall_o  = bus.req_i & ~bus.ack_o;
  assign unused_paddr = ^bus.paddr_i;

  // Address, data and byte enables are captured into the SRAM output
  // registers at acceptance, so they double as the latched request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      we_q        <= 1'b0;
      bus.rdata_o <= '0;
      bus.ack_o   <= 1'b0;
      bus.err_o   <= 1'b0;
      sram_addr_o <= '0;
      sram_dout_o <= '0;
      sram_doe_o  <= 1'b0;
      sram_be_n_o <= 4'hF;
      sram_ce_n_o <= 2'b11;
      sram_oe_n_o <= 1'b1;
      sram_we_n_o <= 1'b1;
    end else begin
      bus.ack_o <= 1'b0;
      bus.err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_i) begin
            if (tlb_exc) begin
              state     <= FAULT;
              bus.ack_o <= 1'b1;
              bus.err_o <= 1'b1;
            end else begin
              state       <= ACCESS;
              cnt         <= '0;
              we_q        <= bus.we_i;
              sram_addr_o <= bus.paddr_i[SRAM_AW+1:2];
              sram_ce_n_o <= bus.paddr_i[22] ? 2'b01 : 2'b10;
              sram_be_n_o <= ~bus.sel_i;
              sram_oe_n_o <= bus.we_i;
              sram_we_n_o <= ~bus.we_i;
              sram_doe_o  <= bus.we_i;
              if (bus.we_i) sram_dout_o <= bus.wdata_i;
            end
          end
        end
        ACCESS: begin
          if (cnt == CNT_LAST) begin
            // Last strobe cycle: data is sampled on the same edge the
            // strobes drop, so oe_n and we_n never overlap between accesses.
            if (!we_q) bus.rdata_o <= sram_din_i;
            sram_ce_n_o <= 2'b11;
            sram_oe_n_o <= 1'b1;
            sram_we_n_o <= 1'b1;
            sram_doe_o  <= 1'b0;
            sram_be_n_o <= 4'hF;
            bus.ack_o   <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        FAULT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - randomized self-checking bench for mem_bus_ctrl
module tb_mem_bus_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mem_init;
  logic        req [2];
  logic        we;
  logic [3:0]  sel;
  logic [31:0] paddr;
  logic [31:0] wdata;
  logic [2:0]  tlb;

  logic [19:0] s_addr [2];
  logic [31:0] s_dout [2];
  logic [31:0] s_din  [2];
  logic        s_doe  [2];
  logic [3:0]  s_be_n [2];
  logic [1:0]  s_ce_n [2];
  logic        s_oe_n [2];
  logic        s_we_n [2];
  logic        ack    [2];
  logic        err    [2];
  logic        stall  [2];
  logic [31:0] rdata  [2];

  mem_bus_ctrl_if b0();
  mem_bus_ctrl_if b1();

  assign b0.req_i = req[0];  assign b1.req_i = req[1];
  assign b0.we_i = we;       assign b1.we_i = we;
  assign b0.sel_i = sel;     assign b1.sel_i = sel;
  assign b0.paddr_i = paddr; assign b1.paddr_i = paddr;
  assign b0.wdata_i = wdata; assign b1.wdata_i = wdata;
  assign b0.tlbm_i = tlb[2]; assign b1.tlbm_i = tlb[2];
  assign b0.tlbl_i = tlb[1]; assign b1.tlbl_i = tlb[1];
  assign b0.tlbs_i = tlb[0]; assign b1.tlbs_i = tlb[0];
  assign ack[0] = b0.ack_o;     assign ack[1] = b1.ack_o;
  assign err[0] = b0.err_o;     assign err[1] = b1.err_o;
  assign stall[0] = b0.stall_o; assign stall[1] = b1.stall_o;
  assign rdata[0] = b0.rdata_o; assign rdata[1] = b1.rdata_o;

  mem_bus_ctrl #(.WAIT_CYCLES(2), .SRAM_AW(20)) dut0 (
    .clk(clk), .rst(rst), .bus(b0),
    .sram_addr_o(s_addr[0]), .sram_dout_o(s_dout[0]), .sram_din_i(s_din[0]),
    .sram_doe_o(s_doe[0]), .sram_be_n_o(s_be_n[0]), .sram_ce_n_o(s_ce_n[0]),
    .sram_oe_n_o(s_oe_n[0]), .sram_we_n_o(s_we_n[0])
  );

  mem_bus_ctrl #(.WAIT_CYCLES(1), .SRAM_AW(20)) dut1 (
    .clk(clk), .rst(rst), .bus(b1),
    .sram_addr_o(s_addr[1]), .sram_dout_o(s_dout[1]), .sram_din_i(s_din[1]),
    .sram_doe_o(s_doe[1]), .sram_be_n_o(s_be_n[1]), .sram_ce_n_o(s_ce_n[1]),
    .sram_oe_n_o(s_oe_n[1]), .sram_we_n_o(s_we_n[1])
  );

  // SRAM devices: [dut][bank][word], word = low 4 address bits
  logic [31:0] sram [2][2][16];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int d = 0; d < 2; d++)
        for (int b = 0; b < 2; b++)
          for (int i = 0; i < 16; i++) sram[d][b][i] <= 32'h0;
    end else begin
      for (int d = 0; d < 2; d++)
        for (int b = 0; b < 2; b++)
          if (!s_ce_n[d][b] && !s_we_n[d])
            for (int l = 0; l < 4; l++)
              if (!s_be_n[d][l]) sram[d][b][s_addr[d][3:0]][8*l +: 8] <= s_dout[d][8*l +: 8];
    end
  end

  assign s_din[0] = !s_ce_n[0][0] ? sram[0][0][s_addr[0][3:0]] :
                    !s_ce_n[0][1] ? sram[0][1][s_addr[0][3:0]] : 32'h0;
  assign s_din[1] = !s_ce_n[1][0] ? sram[1][0][s_addr[1][3:0]] :
                    !s_ce_n[1][1] ? sram[1][1][s_addr[1][3:0]] : 32'h0;

  // Reference model: memory contents and last completed read per DUT
  logic [31:0] ref_mem [2][2][16];
  logic [31:0] exp_rdata [2];
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic ref_write(input int d, input logic bank, input logic [3:0] idx,
                           input logic [3:0] s, input logic [31:0] wd);
    for (int l = 0; l < 4; l++)
      if (s[l]) ref_mem[d][bank][idx][8*l +: 8] = wd[8*l +: 8];
  endtask

  // One request on dut d; checks every cycle from request to ack.
  task automatic txn(input int d, input logic t_we, input logic [3:0] t_sel,
                     input logic [31:0] t_paddr, input logic [31:0] t_wdata,
                     input logic [2:0] t_tlb, input bit scramble);
    int w, kexp;
    bit fault, act;
    logic bank, req_s;
    logic [3:0] idx, exp_be;
    logic [19:0] exp_addr;
    logic [1:0] exp_ce;
    w = (d == 0) ? 2 : 1;
    fault = |t_tlb;
    kexp = fault ? 1 : w + 1;
    bank = t_paddr[22];
    idx = t_paddr[5:2];
    exp_be = ~t_sel;
    exp_addr = t_paddr[21:2];
    exp_ce = bank ? 2'b01 : 2'b10;
    @(posedge clk); #1;
    we = t_we; sel = t_sel; paddr = t_paddr; wdata = t_wdata; tlb = t_tlb; req[d] = 1'b1;
    for (int cyc = 0; cyc <= kexp; cyc++) begin
      @(negedge clk);
      act = !fault && cyc >= 1 && cyc <= w;
      req_s = req[d];
      check("ack", ack[d], cyc == kexp);
      check("stall", stall[d], req_s && cyc != kexp);
      check("ce_n", s_ce_n[d], act ? exp_ce : 2'b11);
      check("oe_n", s_oe_n[d], !(act && !t_we));
      check("we_n", s_we_n[d], !(act && t_we));
      check("doe", s_doe[d], act && t_we);
      if (act) begin
        check("addr", s_addr[d], exp_addr);
        check("be_n", s_be_n[d], exp_be);
        if (t_we) check("dout", s_dout[d], t_wdata);
      end
      if (cyc == kexp) begin
        check("err", err[d], fault);
        if (!fault) begin
          if (t_we) ref_write(d, bank, idx, t_sel, t_wdata);
          else exp_rdata[d] = ref_mem[d][bank][idx];
        end
        check("rdata", rdata[d], exp_rdata[d]);
      end else if (cyc == 1 && scramble) begin
        we = ~t_we; sel = 4'($urandom); paddr = $urandom; wdata = $urandom;
        tlb = 3'($urandom);
        if ($urandom_range(3) == 0) req[d] = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      req[0] = 1'b0; req[1] = 1'b0;
    end
  endtask

  task automatic rand_txn(input int d);
    logic [2:0] tl;
    tl = ($urandom_range(7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
    txn(d, 1'($urandom), 4'($urandom), $urandom, $urandom, tl, $urandom_range(1) == 1);
    if ($urandom_range(3) == 0) idle($urandom_range(1, 3));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; mem_init = 1'b1;
    req[0] = 1'b0; req[1] = 1'b0;
    we = 1'b0; sel = 4'h0; paddr = 32'h0; wdata = 32'h0; tlb = 3'b000;
    for (int d = 0; d < 2; d++) begin
      exp_rdata[d] = 32'h0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 16; i++) ref_mem[d][b][i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; mem_init = 1'b0;

    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_ce_n", s_ce_n[d], 2'b11);
      check("rst_oe_n", s_oe_n[d], 1'b1);
      check("rst_we_n", s_we_n[d], 1'b1);
      check("rst_doe", s_doe[d], 1'b0);
      check("rst_be_n", s_be_n[d], 4'hF);
      check("rst_addr", s_addr[d], 20'h0);
      check("rst_dout", s_dout[d], 32'h0);
      check("rst_ack", ack[d], 1'b0);
      check("rst_err", err[d], 1'b0);
      check("rst_rdata", rdata[d], 32'h0);
    end

    // Reset for two cycles in the middle of a write
    @(posedge clk); #1;
    we = 1'b1; sel = 4'hF; paddr = 32'h0000_2008; wdata = 32'h1234_5678; req[0] = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0; req[0] = 1'b0;
    ref_write(0, 1'b0, 4'd2, 4'hF, 32'h1234_5678);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("mid_rst_ce_n", s_ce_n[0], 2'b11);
      check("mid_rst_oe_n", s_oe_n[0], 1'b1);
      check("mid_rst_we_n", s_we_n[0], 1'b1);
      check("mid_rst_doe", s_doe[0], 1'b0);
      check("mid_rst_ack", ack[0], 1'b0);
    end

    txn(0, 1'b1, 4'hF, 32'h0000_1004, 32'hDEAD_BEEF, 3'b000, 1'b0);
    txn(0, 1'b0, 4'hF, 32'h0000_1004, 32'h0, 3'b000, 1'b0);
    check("readback", rdata[0], 32'hDEAD_BEEF);
    txn(0, 1'b1, 4'b1100, 32'h0040_0008, 32'hCAFE_F00D, 3'b000, 1'b0);
    txn(0, 1'b0, 4'b0011, 32'h0040_0008, 32'h0, 3'b000, 1'b0);
    check("ext_read", rdata[0], 32'hCAFE_0000);
    txn(0, 1'b0, 4'hF, 32'h0000_1004, 32'h0, 3'b001, 1'b0);
    check("fault_rdata_hold", rdata[0], 32'hCAFE_0000);
    txn(0, 1'b1, 4'h0, 32'h0000_1004, 32'h0, 3'b000, 1'b0);
    txn(0, 1'b0, 4'hF, 32'h0000_1004, 32'h0, 3'b000, 1'b0);
    check("sel0_no_write", rdata[0], 32'hDEAD_BEEF);
    idle(2);

    for (int n = 0; n < 300; n++) rand_txn(0);
    idle(2);

    txn(1, 1'b1, 4'hF, 32'h0000_1004, 32'hA5A5_5A5A, 3'b000, 1'b0);
    txn(1, 1'b0, 4'hF, 32'h0000_1004, 32'h0, 3'b000, 1'b0);
    check("w1_readback", rdata[1], 32'hA5A5_5A5A);
    for (int n = 0; n < 80; n++) rand_txn(1);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
